// File: rtl/ball_sequencer.sv
// ball_sequencer: game-flow controller shared by the x/y ball movers.
//   Sequences IDLE -> PLAY -> MISS -> IDLE/OVER and issues one-cycle step enables
//   from a single down-counting tick scheduler whose period shrinks with the speed level.
// Ports:
//   pclk, reset          - pixel clock, synchronous active-high reset
//   launch               - mouse button level; its rising edge serves / restarts
//   y_pos [11:0]         - ball centre y, compared against Y_FLOOR for a miss
//   paddle_hit           - one-cycle pulse from collision logic
//   step, ball_rst       - one-cycle pulses to the movers
//   lives [1:0], speed_lvl [2:0], playing, game_over - registered status
// Build option: define BALL_SPEEDUP_EN to enable the hit counter and speed levels;
//   without it speed_lvl is 0 and the step period is fixed at TICK_BASE.

module ball_sequencer #(
  parameter int unsigned TICK_BASE      = 800_000,
  parameter int unsigned TICK_DEC       = 100_000,
  parameter int unsigned TICK_MIN       = 200_000,
  parameter int unsigned HITS_PER_LEVEL = 8,
  parameter int unsigned LIVES_INIT     = 3,
  parameter int unsigned Y_FLOOR        = 757
) (
  input  logic        pclk,
  input  logic        reset,
  input  logic        launch,
  input  logic [11:0] y_pos,
  input  logic        paddle_hit,
  output logic        step,
  output logic        ball_rst,
  output logic [1:0]  lives,
  output logic [2:0]  speed_lvl,
  output logic        playing,
  output logic        game_over
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    MISS = 2'd2,
    OVER = 2'd3
  } state_t;

  localparam logic [11:0] FLOOR_Y = 12'(Y_FLOOR);
  localparam logic [1:0]  LIVES_RST = 2'(LIVES_INIT);

  state_t      state, state_nxt;
  logic        launch_q;
  logic        launch_rise;
  logic        miss;
  logic [31:0] period;
  logic [31:0] tick_cnt, tick_nxt;
  logic [1:0]  lives_nxt;
  logic        step_nxt;
  logic        ball_rst_nxt;

  assign launch_rise = launch & ~launch_q;
  // A paddle hit in the same cycle as a floor crossing always saves the ball.
  assign miss        = (y_pos >= FLOOR_Y) && !paddle_hit;

`ifdef BALL_SPEEDUP_EN
  localparam int HIT_W = $clog2(HITS_PER_LEVEL) + 1;

  logic [HIT_W-1:0] hit_cnt;
  logic [HIT_W-1:0] hit_inc;
  logic             hit_wrap;
  logic [2:0]       lvl;
  logic [31:0]      dec_cur, dec_next;
  logic             lvl_blocked;

  assign hit_inc  = hit_cnt + HIT_W'(1);
  assign hit_wrap = (hit_inc == HIT_W'(HITS_PER_LEVEL));
  assign dec_cur  = 32'(lvl) * TICK_DEC;
  assign dec_next = (32'(lvl) + 32'd1) * TICK_DEC;
  // Compared as a reduction against the headroom so the subtraction cannot wrap.
  assign lvl_blocked = (lvl == 3'd7) || (dec_next > TICK_BASE - TICK_MIN);
  assign period      = (dec_cur > TICK_BASE - TICK_MIN) ? TICK_MIN : TICK_BASE - dec_cur;
  assign speed_lvl   = lvl;

  always_ff @(posedge pclk) begin
    if (reset) begin
      hit_cnt <= '0;
      lvl     <= '0;
    end else if (state_nxt == MISS) begin
      hit_cnt <= '0;
      lvl     <= '0;
    end else if (state == PLAY && paddle_hit) begin
      if (hit_wrap) begin
        hit_cnt <= '0;
        if (!lvl_blocked) lvl <= lvl + 3'd1;
      end else begin
        hit_cnt <= hit_inc;
      end
    end
  end
`else
  assign speed_lvl = 3'd0;
  assign period    = TICK_BASE;
`endif

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (launch_rise) state_nxt = PLAY;
      PLAY: if (miss) state_nxt = MISS;
      // lives was already decremented on entry, so 0 here means the last life went.
      MISS: state_nxt = (lives == 2'd0) ? OVER : IDLE;
      OVER: if (launch_rise) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Tick scheduler and registered-output precompute. The counter is held at
  // period-1 outside PLAY; the period is only sampled on reload, so a level
  // change never truncates a count in progress.
  always_comb begin
    tick_nxt     = period - 32'd1;
    lives_nxt    = lives;
    ball_rst_nxt = 1'b0;
    if (state == PLAY && state_nxt == PLAY && tick_cnt != 32'd0) begin
      tick_nxt = tick_cnt - 32'd1;
    end
    // step is registered, so it is aligned to the cycle the counter shows 0.
    step_nxt = (state_nxt == PLAY) && (tick_nxt == 32'd0);
    if (state_nxt == MISS) begin
      lives_nxt    = lives - 2'd1;
      ball_rst_nxt = 1'b1;
    end else if (state == OVER && launch_rise) begin
      lives_nxt    = LIVES_RST;
      ball_rst_nxt = 1'b1;
    end
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      state     <= IDLE;
      launch_q  <= 1'b0;
      tick_cnt  <= TICK_BASE - 32'd1;
      lives     <= LIVES_RST;
      step      <= 1'b0;
      ball_rst  <= 1'b0;
      playing   <= 1'b0;
      game_over <= 1'b0;
    end else begin
      state     <= state_nxt;
      launch_q  <= launch;
      tick_cnt  <= tick_nxt;
      lives     <= lives_nxt;
      step      <= step_nxt;
      ball_rst  <= ball_rst_nxt;
      playing   <= (state_nxt == PLAY);
      game_over <= (state_nxt == OVER);
    end
  end

endmodule

// File: tb/tb_ball_sequencer.sv
// tb_ball_sequencer: directed bench for ball_sequencer with a step-time scoreboard.
//   Cycle k is the interval after the k-th rising edge; inputs change and outputs
//   are sampled on the falling edge inside that interval.

module tb_ball_sequencer;

  logic        pclk;
  logic        reset;
  logic        launch;
  logic [11:0] y_pos;
  logic        paddle_hit;
  logic        step;
  logic        ball_rst;
  logic [1:0]  lives;
  logic [2:0]  speed_lvl;
  logic        playing;
  logic        game_over;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int exp_c;
  int sb[$];

`ifdef BALL_SPEEDUP_EN
  localparam bit SPD = 1'b1;
`else
  localparam bit SPD = 1'b0;
`endif

  ball_sequencer #(
    .TICK_BASE      (10),
    .TICK_DEC       (2),
    .TICK_MIN       (6),
    .HITS_PER_LEVEL (2),
    .LIVES_INIT     (2),
    .Y_FLOOR        (757)
  ) dut (
    .pclk       (pclk),
    .reset      (reset),
    .launch     (launch),
    .y_pos      (y_pos),
    .paddle_hit (paddle_hit),
    .step       (step),
    .ball_rst   (ball_rst),
    .lives      (lives),
    .speed_lvl  (speed_lvl),
    .playing    (playing),
    .game_over  (game_over)
  );

  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  always @(posedge pclk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  // Every step pulse must match the next scheduled step cycle.
  always @(negedge pclk) begin
    if (step === 1'b1) begin
      n_vec++;
      assert (sb.size() != 0) else begin
        n_err++;
        $error("FAIL step_unexpected: observed step at cycle %0d, expected none", cyc);
      end
      if (sb.size() != 0) begin
        exp_c = sb.pop_front();
        assert (cyc === exp_c) else begin
          n_err++;
          $error("FAIL step_time: observed step at cycle %0d, expected cycle %0d", cyc, exp_c);
        end
      end
    end
  end

  task automatic go(input int k);
    while (cyc < k) @(negedge pclk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  initial begin
    reset      = 1'b1;
    launch     = 1'b0;
    y_pos      = 12'd100;
    paddle_hit = 1'b0;

    go(3);
    check("rst_step", 32'(step), 0);
    check("rst_ball_rst", 32'(ball_rst), 0);
    check("rst_lives", 32'(lives), 2);
    check("rst_speed", 32'(speed_lvl), 0);
    check("rst_playing", 32'(playing), 0);
    check("rst_game_over", 32'(game_over), 0);
    reset = 1'b0;

    // Serve: launch rises in cycle 5.
    go(5);
    check("idle_not_playing", 32'(playing), 0);
    launch = 1'b1;
    sb.push_back(15);
    sb.push_back(25);
    sb.push_back(35);
    go(6);
    check("launch_playing", 32'(playing), 1);

    // Two hits; the second coincides with the ball below the floor.
    go(36);
    paddle_hit = 1'b1;
    go(37);
    y_pos = 12'd760;
    go(38);
    paddle_hit = 1'b0;
    y_pos      = 12'd100;
    check("hit_at_floor_playing", 32'(playing), 1);
    check("hit_at_floor_no_rst", 32'(ball_rst), 0);
    check("hit_at_floor_lives", 32'(lives), 2);
    check("speed_after_2_hits", 32'(speed_lvl), SPD ? 1 : 0);
    if (SPD) begin
      sb.push_back(45); sb.push_back(53); sb.push_back(61);
      sb.push_back(67); sb.push_back(73); sb.push_back(79);
    end else begin
      sb.push_back(45); sb.push_back(55); sb.push_back(65); sb.push_back(75);
    end

    // Launch edge during PLAY is ignored.
    go(40);
    launch = 1'b0;
    go(41);
    launch = 1'b1;
    go(42);
    check("rise_in_play_ignored", 32'(playing), 1);

    // Eight more hits: level saturates at 2 (or stays 0 without speedup).
    go(54);
    paddle_hit = 1'b1;
    go(56);
    check("speed_after_4_hits", 32'(speed_lvl), SPD ? 2 : 0);
    go(62);
    paddle_hit = 1'b0;
    check("speed_saturated", 32'(speed_lvl), SPD ? 2 : 0);
    go(70);
    launch = 1'b0;

    // First miss.
    go(80);
    check("pre_miss_playing", 32'(playing), 1);
    y_pos = 12'd757;
    go(81);
    y_pos = 12'd100;
    check("miss1_ball_rst", 32'(ball_rst), 1);
    check("miss1_lives", 32'(lives), 1);
    check("miss1_speed_clr", 32'(speed_lvl), 0);
    check("miss1_playing", 32'(playing), 0);
    go(82);
    check("miss1_rst_pulse_end", 32'(ball_rst), 0);
    check("miss1_idle_over", 32'(game_over), 0);
    check("miss1_idle_lives", 32'(lives), 1);

    // Second serve and miss -> game over.
    go(85);
    launch = 1'b1;
    sb.push_back(95);
    go(86);
    check("serve2_playing", 32'(playing), 1);
    go(100);
    y_pos = 12'd757;
    go(101);
    y_pos = 12'd100;
    check("miss2_ball_rst", 32'(ball_rst), 1);
    check("miss2_lives", 32'(lives), 0);
    go(102);
    check("over_game_over", 32'(game_over), 1);
    check("over_playing", 32'(playing), 0);
    go(110);
    check("over_held_launch", 32'(game_over), 1);
    launch = 1'b0;

    // Restart from OVER.
    go(112);
    launch = 1'b1;
    go(113);
    check("restart_ball_rst", 32'(ball_rst), 1);
    check("restart_lives", 32'(lives), 2);
    check("restart_game_over", 32'(game_over), 0);
    go(114);
    check("restart_rst_end", 32'(ball_rst), 0);
    go(130);
    check("held_launch_no_play", 32'(playing), 0);
    launch = 1'b0;

    // Reset lands during the MISS cycle.
    go(132);
    launch = 1'b1;
    go(133);
    check("serve3_playing", 32'(playing), 1);
    go(135);
    y_pos = 12'd757;
    go(136);
    check("miss3_ball_rst", 32'(ball_rst), 1);
    check("miss3_lives", 32'(lives), 1);
    reset  = 1'b1;
    launch = 1'b0;
    y_pos  = 12'd100;
    go(137);
    check("rst_in_miss_playing", 32'(playing), 0);
    check("rst_in_miss_lives", 32'(lives), 2);
    check("rst_in_miss_ball_rst", 32'(ball_rst), 0);
    check("rst_in_miss_over", 32'(game_over), 0);
    reset = 1'b0;

    go(150);
    check("all_steps_seen", 32'(sb.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ball_sequencer.md
# ball_sequencer

Game-flow controller for the ball movers. Replaces the free-running per-mover delay counters with one shared step scheduler that issues single-cycle step enables to the x and y ball position blocks. It owns the serve/play/miss/game-over sequence, the lives count and a speed level that rises with paddle hits. It sits between the mouse/collision logic and the ball position registers, all in the `pclk` domain.

## Interface
- `TICK_BASE`, 800_000 — step period in `pclk` cycles at speed level 0
- `TICK_DEC`, 100_000 — period reduction per speed level
- `TICK_MIN`, 200_000 — period floor
- `HITS_PER_LEVEL`, 8 — paddle hits per speed-level increment
- `LIVES_INIT`, 3 — lives at reset and restart; 1..3
- `Y_FLOOR`, 757 — miss threshold on ball `y_pos`, which is the ball centre
- `pclk` input 1 — pixel clock; the only clock
- `reset` input 1 — synchronous, active-high
- `launch` input 1 — mouse left button, level; rising edge used
- `y_pos` input 12 — current ball y position
- `paddle_hit` input 1 — one-cycle pulse, ball bounced off paddle
- `step` output 1 — one-cycle pulse; movers advance one pixel
- `ball_rst` output 1 — one-cycle pulse; movers reload start position and direction
- `lives` output 2 — remaining lives
- `speed_lvl` output 3 — current speed level
- `playing` output 1 — high in PLAY
- `game_over` output 1 — high in OVER

## Operation
- States: IDLE (ball held at start), PLAY, MISS, OVER; encoded in 2 bits.
- Launch edge: `launch_q` is `launch` registered; `launch_rise = launch & ~launch_q`.
- IDLE: on `launch_rise`, go to PLAY. Tick counter is held at `period-1` and `step` stays 0.
- PLAY: tick counter counts down. At 0 it pulses `step` and reloads `period-1`.
- PLAY miss: if `y_pos >= Y_FLOOR` and `paddle_hit` is 0 in the same cycle, go to MISS. If both occur in the same cycle, `paddle_hit` wins: the hit is counted and there is no miss.
- MISS lasts exactly 1 cycle. During it: `ball_rst` = 1, `lives` decrements, `speed_lvl` and the hit counter clear, and `step` = 0.
- MISS exit: to OVER if `lives` was 1 on entering MISS, otherwise to IDLE.
- OVER: `game_over` = 1. On `launch_rise`: `lives` ← `LIVES_INIT`, `ball_rst` pulses, and state goes to IDLE.
- Hit counter: counts `paddle_hit` only in PLAY and has width ⌈log2(HITS_PER_LEVEL)⌉+1. On reaching `HITS_PER_LEVEL` it clears and `speed_lvl` increments. The increment is blocked once `TICK_BASE - (speed_lvl+1)*TICK_DEC < TICK_MIN`, or once `speed_lvl` = 7.
- Period = `TICK_BASE - speed_lvl*TICK_DEC`, 32-bit unsigned, never below `TICK_MIN`. A new period takes effect at the next reload only; the count in progress is not truncated.
- `launch_rise` in PLAY or MISS is ignored.

## Timing
- Reset values: state IDLE, `lives` = `LIVES_INIT`, `speed_lvl` 0, hit counter 0, tick counter `TICK_BASE-1`, `launch_q` 0. `step`, `ball_rst`, `playing` and `game_over` are all 0.
- All outputs are registered.
- `launch_rise` at cycle N: `playing` = 1 at N+1. The first `step` occurs at N+`period`, and steps repeat every `period` cycles after that.
- Miss condition at cycle N: `ball_rst` and the `lives` decrement appear at N+1, and the next state is valid at N+2.
- `reset` takes priority over every event, including mid-MISS and mid-count. A pending `step` is discarded.

## Configuration
- `BALL_SPEEDUP_EN` defined: speed levels and the hit counter behave as described above.
- `BALL_SPEEDUP_EN` undefined: the hit counter and level logic are removed, `speed_lvl` is tied to 0, and the period is fixed at `TICK_BASE`. `paddle_hit` is then used only for miss suppression.

## Test plan
Parameters for the bench: `TICK_BASE`=10, `TICK_DEC`=2, `TICK_MIN`=6, `HITS_PER_LEVEL`=2, `LIVES_INIT`=2, `Y_FLOOR`=757.
- Reset, then `launch` rises at cycle 5 → `playing` = 1 at cycle 6; `step` pulses at cycles 15, 25 and 35; `step` stays 0 before launch.
- In PLAY, 2 `paddle_hit` pulses → `speed_lvl` = 1 and the step spacing becomes 8 from the next reload. After 4 more hits, `speed_lvl` saturates at 2 with spacing 6.
- `y_pos` = 757 with `paddle_hit` = 0 → one `ball_rst` pulse, `lives` 2→1, `speed_lvl` → 0, then IDLE. A second miss gives `lives` 0, `game_over` = 1 and no further `step`.
- `y_pos` = 760 and `paddle_hit` in the same cycle → no MISS, the hit is counted, and `playing` stays 1.
- In OVER, a `launch` rise → `ball_rst` pulse, `lives` = 2, then IDLE. A held `launch` does not auto-start PLAY.
- `reset` asserted during the MISS cycle → next cycle shows IDLE, `lives` = 2, `ball_rst` 0. With `BALL_SPEEDUP_EN` undefined, 10 hits leave the step spacing at 10.
